// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and byte-addressed data memory.
// Optional alignment checking is enabled by defining SB_ALIGN_CHECK_EN.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_mode,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [2:0]    ld_mode,
    output logic          ld_stall,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_write_data,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic [2:0]    mem_mode,
    output logic          empty,
    output logic          full,
    output logic          misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [2:0]    mode_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;
    logic overlap;
    logic ld_issue;
    logic st_mis;
    logic ld_mis;

    function automatic logic [2:0] st_size(input logic [2:0] m);
        case (m)
            3'b001:  st_size = 3'd2;
            3'b011:  st_size = 3'd1;
            default: st_size = 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] ld_size(input logic [2:0] m);
        case (m)
            3'b001, 3'b010: ld_size = 3'd2;
            3'b011, 3'b100: ld_size = 3'd1;
            default:        ld_size = 3'd4;
        endcase
    endfunction

    // One extra bit on the range ends avoids aliasing at the top of memory.
    function automatic logic ovl(
        input logic [AW-1:0] a,
        input logic [2:0]    sa,
        input logic [AW-1:0] b,
        input logic [2:0]    sb
    );
        logic [AW:0] a_lo;
        logic [AW:0] b_lo;
        logic [AW:0] a_hi;
        logic [AW:0] b_hi;
        a_lo = {1'b0, a};
        b_lo = {1'b0, b};
        a_hi = a_lo + (AW+1)'(sa) - (AW+1)'(1);
        b_hi = b_lo + (AW+1)'(sb) - (AW+1)'(1);
        ovl  = (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

`ifdef SB_ALIGN_CHECK_EN
    function automatic logic misal(
        input logic [AW-1:0] a,
        input logic [2:0]    sz
    );
        case (sz)
            3'd4:    misal = a[1:0] != 2'b00;
            3'd2:    misal = a[0];
            default: misal = 1'b0;
        endcase
    endfunction

    assign st_mis = st_valid && misal(st_addr, st_size(st_mode));
    assign ld_mis = ld_valid && misal(ld_addr, ld_size(ld_mode));
`else
    assign st_mis = 1'b0;
    assign ld_mis = 1'b0;
`endif

    assign empty    = count_q == '0;
    assign full     = count_q == CW'(DEPTH);
    assign st_ready = reset && !full;
    assign misalign = reset && ((st_mis && st_ready) || ld_mis);

    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] &&
                ovl(addr_q[i], st_size(mode_q[i]),
                    ld_addr, ld_size(ld_mode)))
                overlap = 1'b1;
        end
    end

    assign ld_issue = reset && ld_valid && !ld_mis && !overlap && !full;
    assign pop      = reset && !ld_issue && !empty;
    assign push     = st_valid && st_ready && !st_mis;
    assign ld_stall = reset && ld_valid && !ld_mis && !ld_issue;

    always_comb begin
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_mode       = '0;
        if (ld_issue) begin
            mem_memread = 1'b1;
            mem_address = 32'(ld_addr);
            mem_mode    = ld_mode;
        end else if (pop) begin
            mem_memwrite   = 1'b1;
            mem_address    = 32'(addr_q[head_q]);
            mem_write_data = data_q[head_q];
            mem_mode       = mode_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mode_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail_q]  <= st_addr;
                data_q[tail_q]  <= st_data;
                mode_q[tail_q]  <= st_mode;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            // A same-edge push cannot target head unless the FIFO is empty.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// A small byte memory model absorbs the drained writes.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_mode;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_mode;
    logic        ld_stall;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [2:0]  mem_mode;
    logic        empty;
    logic        full;
    logic        misalign;

    int errs;
    int checks;

    logic [7:0] tmem [0:1023];

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_mode       (st_mode),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_mode       (ld_mode),
        .ld_stall      (ld_stall),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_mode      (mem_mode),
        .empty         (empty),
        .full          (full),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_memwrite) begin
            case (mem_mode)
                3'b011: tmem[mem_address[9:0]] <= mem_write_data[7:0];
                3'b001: begin
                    tmem[mem_address[9:0]]         <= mem_write_data[7:0];
                    tmem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                end
                default: begin
                    tmem[mem_address[9:0]]         <= mem_write_data[7:0];
                    tmem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                    tmem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
                    tmem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
                end
            endcase
        end
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        rd_word = {tmem[a[9:0] + 10'd3], tmem[a[9:0] + 10'd2],
                   tmem[a[9:0] + 10'd1], tmem[a[9:0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_mode  = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_mode  = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mode  = m;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] m);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_mode  = m;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        foreach (tmem[i]) tmem[i] = 8'h00;
        reset = 1'b0;
        idle();

        // Reset held: everything quiet even with requests present
        @(negedge clk);
        store(32'h10, 32'h1, 3'b000);
        load(32'h40, 3'b000);
        #1;
        chk("rst_st_ready", st_ready, 0);
        chk("rst_ld_stall", ld_stall, 0);
        chk("rst_memread", mem_memread, 0);
        chk("rst_memwrite", mem_memwrite, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_misalign", misalign, 0);
        step();
        reset = 1'b1;
        step();

        // Word store then drain on the following cycle
        store(32'h10, 32'hDEADBEEF, 3'b000);
        #1;
        chk("t1_ready", st_ready, 1);
        chk("t1_nowrite", mem_memwrite, 0);
        step();
        #1;
        chk("t1_write", mem_memwrite, 1);
        chk("t1_addr", mem_address, 32'h10);
        chk("t1_data", mem_write_data, 32'hDEADBEEF);
        chk("t1_mode", mem_mode, 0);
        step();
        #1;
        chk("t1_empty", empty, 1);
        chk("t1_mem", rd_word(32'h10), 32'hDEADBEEF);

        // Fill while a non-overlapping load hogs the port
        for (int i = 0; i < 4; i++) begin
            store(32'h200 + 32'(4 * i), 32'h100 + 32'(i), 3'b000);
            load(32'h100, 3'b000);
            #1;
            chk("t2_ld_issue", mem_memread, 1);
            step();
        end
        load(32'h100, 3'b000);
        #1;
        chk("t2_full", full, 1);
        chk("t2_st_ready", st_ready, 0);
        chk("t2_stall", ld_stall, 1);
        chk("t2_drain", mem_memwrite, 1);
        chk("t2_drain_addr", mem_address, 32'h200);
        step();
        load(32'h100, 3'b000);
        #1;
        chk("t2_notfull", full, 0);
        chk("t2_ld_go", mem_memread, 1);
        chk("t2_ld_nostall", ld_stall, 0);
        chk("t2_ld_addr", mem_address, 32'h100);
        step();
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t2_tail_drain", mem_address, 32'h200 + 32'(4 * i));
            step();
        end
        #1;
        chk("t2_empty", empty, 1);

        // Byte store overlapping a following word load
        store(32'h21, 32'h000000AB, 3'b011);
        step();
        load(32'h20, 3'b000);
        #1;
        chk("t3_stall", ld_stall, 1);
        chk("t3_drain", mem_memwrite, 1);
        chk("t3_addr", mem_address, 32'h21);
        chk("t3_data", mem_write_data, 32'hAB);
        chk("t3_mode", mem_mode, 3'b011);
        step();
        load(32'h20, 3'b000);
        #1;
        chk("t3_ld_go", mem_memread, 1);
        chk("t3_ld_nostall", ld_stall, 0);
        chk("t3_ld_addr", mem_address, 32'h20);
        chk("t3_rdata", rd_word(32'h20), 32'h0000AB00);
        step();

        // Half store, adjacent byte load does not overlap
        store(32'h22, 32'h00001234, 3'b001);
        step();
        load(32'h24, 3'b011);
        #1;
        chk("t4_ld_go", mem_memread, 1);
        chk("t4_nostall", ld_stall, 0);
        chk("t4_nowrite", mem_memwrite, 0);
        step();
        #1;
        chk("t4_drain", mem_memwrite, 1);
        chk("t4_addr", mem_address, 32'h22);
        chk("t4_mode", mem_mode, 3'b001);
        step();
        #1;
        chk("t4_empty", empty, 1);
        chk("t4_mem", rd_word(32'h20), 32'h1234AB00);

        // Build count=2, then six push+pop edges across the pointer wrap
        for (int i = 0; i < 2; i++) begin
            store(32'h400 + 32'(4 * i), 32'(i), 3'b000);
            load(32'h300, 3'b000);
            step();
        end
        for (int i = 2; i < 8; i++) begin
            store(32'h400 + 32'(4 * i), 32'(i), 3'b000);
            #1;
            chk("t5_drain_addr", mem_address, 32'h400 + 32'(4 * (i - 2)));
            chk("t5_drain_data", mem_write_data, 32'(i - 2));
            chk("t5_not_empty", empty, 0);
            chk("t5_not_full", full, 0);
            step();
        end
        for (int i = 6; i < 8; i++) begin
            #1;
            chk("t5_last_addr", mem_address, 32'h400 + 32'(4 * i));
            step();
        end
        #1;
        chk("t5_empty", empty, 1);
        chk("t5_idle", mem_memwrite, 0);

`ifdef SB_ALIGN_CHECK_EN
        store(32'h13, 32'h55, 3'b000);
        #1;
        chk("t6_st_mis", misalign, 1);
        chk("t6_st_ready", st_ready, 1);
        step();
        #1;
        chk("t6_empty", empty, 1);
        chk("t6_nowrite", mem_memwrite, 0);
        load(32'h31, 3'b001);
        #1;
        chk("t6_ld_mis", misalign, 1);
        chk("t6_ld_noread", mem_memread, 0);
        chk("t6_ld_nostall", ld_stall, 0);
        step();
`else
        store(32'h13, 32'h55, 3'b000);
        #1;
        chk("t6_no_mis", misalign, 0);
        step();
        #1;
        chk("t6_write", mem_memwrite, 1);
        chk("t6_addr", mem_address, 32'h13);
        step();
`endif

        // Reset in the middle of pending stores discards them
        store(32'h500, 32'h9, 3'b000);
        step();
        store(32'h504, 32'hA, 3'b000);
        load(32'h600, 3'b000);
        step();
        #1;
        reset = 1'b0;
        #1;
        chk("t7_empty", empty, 1);
        chk("t7_nowrite", mem_memwrite, 0);
        step();
        reset = 1'b1;
        step();
        #1;
        chk("t7_stay_idle", mem_memwrite, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
